vga_plot_sched: RTL
===================

Name: vga_plot_sched

Overview:
- Pixel-write scheduler in front of vga_adapter (160x120, 3-bit colour, one pixel per clock).
- Shares the adapter's single x/y/colour/plot port between two pixel requesters using valid/ready handshakes and round-robin arbitration.
- Contains a full-screen clear sequencer that takes priority over both requesters.
- Outputs are registered and drive vga_adapter .x/.y/.colour/.plot directly.

Parameters:
- X_MAX, 160, horizontal pixel count; valid x is 0..X_MAX-1.
- Y_MAX, 120, vertical pixel count; valid y is 0..Y_MAX-1.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOR_W, 3, colour width.

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- clear_req  in  1  request a full-screen fill with clear_colour.
- clear_colour  in  COLOR_W  fill colour; sampled only when the clear starts.
- clear_busy  out  1  high while the clear sequence runs.
- req0_valid  in  1  requester 0 has a pixel.
- req0_ready  out  1  requester 0 pixel accepted this cycle.
- req0_x  in  X_W  requester 0 x coordinate.
- req0_y  in  Y_W  requester 0 y coordinate.
- req0_colour  in  COLOR_W  requester 0 colour.
- req1_valid, req1_ready, req1_x, req1_y, req1_colour: same as requester 0, for requester 1.
- x  out  X_W  to adapter.
- y  out  Y_W  to adapter.
- colour  out  COLOR_W  to adapter.
- plot  out  1  to adapter; one-cycle write strobe per pixel.

Behaviour:
- Reset (asynchronous, resetn=0): state=ARB; x=0, y=0, colour=0, plot=0, clear_busy=0; last_grant=1, so requester 0 wins the first tie.
- States: ARB and CLEAR.
- ARB, clear_req=1:
  - Enter CLEAR next cycle; latch clear_colour; scan counters cx=0, cy=0.
  - Both readies are 0 in that cycle; clear beats pending requests.
- ARB, clear_req=0:
  - Grant is combinational from valids and last_grant.
  - One valid: that requester wins.
  - Both valid: the requester that is not last_grant wins.
  - reqN_ready = (state==ARB) & ~clear_req & grant==N. Only one ready is ever high.
- Handshake: a transfer occurs when valid & ready are both high in a cycle.
  - Requesters hold x/y/colour stable while valid=1 and ready=0.
  - valid may drop without a transfer; there is no penalty.
- Accepted pixel:
  - Registered into x/y/colour; plot=1 in the next cycle (latency 1).
  - last_grant updates to the accepted port.
  - Back-to-back accepts sustain one pixel per clock.
- No accept in a cycle: plot=0 next cycle; x/y/colour hold their last values.
- Out-of-range coordinate (x>=X_MAX or y>=Y_MAX):
  - Handshake completes (ready=1) and last_grant updates.
  - plot=0 next cycle; x/y/colour are not updated.
- CLEAR:
  - Each cycle emits (cx,cy,latched colour) with plot=1 next cycle.
  - Scan order is row-major: cx increments; at cx=X_MAX-1, cx wraps to 0 and cy increments.
  - After (X_MAX-1,Y_MAX-1) is emitted, return to ARB.
  - Exactly X_MAX*Y_MAX = 19200 plot pulses per clear.
- clear_busy: 1 for every cycle the state is CLEAR; it drops in the cycle the state returns to ARB.
- clear_req while in CLEAR: ignored and not queued. If it is still high on return to ARB, a new clear starts immediately.
- Requests during CLEAR: ready=0; requests stall and nothing is lost.
- Reset mid-clear: abort immediately; outputs go to reset values. Partial frame contents in the adapter are not repaired.

Optional Feature:
- Macro: VGA_PLOT_SCHED_DROP_CNT_EN.
- Defined:
  - Adds output drop_count [7:0], an 8-bit saturating count of accepted out-of-range pixels from either port.
  - Reset value 0. It saturates at 255 and is cleared at the start of each clear sequence.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset, then req0_valid=1 with (10,20,3b101) -> req0_ready=1 that cycle; next cycle x=10, y=20, colour=5, plot=1; the following cycle plot=0.
- req0 and req1 valid continuously with distinct pixels, no clear -> grants alternate 0,1,0,1 with plot high every cycle; each port advances once per two cycles.
- clear_req=1 for one cycle, clear_colour=3b010 -> clear_busy high 19200 cycles; 19200 plot pulses, first (0,0), last (159,119), all colour 2; req1_valid held throughout sees ready=0 until clear_busy falls, then is accepted.
- req1 pixel (160,5) and then (3,120) -> both accepted with ready=1; no plot pulses; x/y keep previous values; with VGA_PLOT_SCHED_DROP_CNT_EN, drop_count=2.
- resetn pulsed low at pixel 5000 of a clear -> plot and clear_busy go 0 immediately; after release state=ARB and a new req0 pixel plots with latency 1.
- clear_req and req0_valid rise in the same ARB cycle -> req0_ready=0; clear runs first; req0 is accepted in the first ARB cycle after the clear.

Source files
------------

// File: rtl/vga_plot_sched.sv
// vga_plot_sched: pixel-write scheduler in front of vga_adapter.
// Two valid/ready pixel requesters share the adapter port with round-robin
// arbitration. A full-screen clear sequencer takes priority over both.
// Optional feature macro: VGA_PLOT_SCHED_DROP_CNT_EN adds drop_count, a
// saturating count of accepted out-of-range pixels.
module vga_plot_sched #(
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_colour,
  output logic               clear_busy,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [X_W-1:0]     req0_x,
  input  logic [Y_W-1:0]     req0_y,
  input  logic [COLOR_W-1:0] req0_colour,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [X_W-1:0]     req1_x,
  input  logic [Y_W-1:0]     req1_y,
  input  logic [COLOR_W-1:0] req1_colour,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot
`ifdef VGA_PLOT_SCHED_DROP_CNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   colour_q, colour_d;
  logic                 plot_q, plot_d;
  logic [X_W-1:0]       cx_q, cx_d;
  logic [Y_W-1:0]       cy_q, cy_d;
  logic [COLOR_W-1:0]   clr_col_q, clr_col_d;

  logic                 in_arb;
  logic                 grant1;
  logic                 accept;
  logic                 in_range;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOR_W-1:0]   sel_colour;

  // Round-robin grant and handshake: requester 1 wins alone or on a tie after requester 0 was last served.
  always_comb begin
    in_arb     = (state_q == ARB);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req1_ready = in_arb & ~clear_req & grant1;
    req0_ready = in_arb & ~clear_req & req0_valid & ~grant1;
    accept     = req0_ready | req1_ready;
    sel_x      = grant1 ? req1_x : req0_x;
    sel_y      = grant1 ? req1_y : req0_y;
    sel_colour = grant1 ? req1_colour : req0_colour;
    in_range   = (sel_x <= X_LAST) & (sel_y <= Y_LAST);
  end

  // Next-state logic: clear scan in CLEAR, arbitration and pixel capture in ARB.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    cx_d         = cx_q;
    cy_d         = cy_q;
    clr_col_d    = clr_col_q;
    case (state_q)
      ARB: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_col_d = clear_colour;
          cx_d      = '0;
          cy_d      = '0;
        end else if (accept) begin
          last_grant_d = grant1;
          if (in_range) begin
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_colour;
            plot_d   = 1'b1;
          end
        end
      end
      CLEAR: begin
        x_d      = cx_q;
        y_d      = cy_q;
        colour_d = clr_col_q;
        plot_d   = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            state_d = ARB;
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State and registered adapter outputs; reset aborts any clear in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      clr_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      clr_col_q    <= clr_col_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign clear_busy = (state_q == CLEAR);

`ifdef VGA_PLOT_SCHED_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Drop counter: zeroed when a clear starts, saturating count of accepted off-screen pixels.
  always_comb begin
    drop_d = drop_q;
    if (in_arb & clear_req) begin
      drop_d = '0;
    end else if (accept & ~in_range & (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule
